// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM state
// encoding, BCD digit width and the add-3 threshold of the double-dabble step.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // A digit at or above this value overflows past 9 when doubled, so it gets +3 first
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One BCD digit of the double-dabble adjust stage: digits >= 5 get +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Pure 4-bit add, no carry to the neighbouring digit
  always_comb begin
    adjusted = digit;
    if (digit >= ADD3_THRESH) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One bit is consumed per
// cycle; the packed BCD result and overflow flag are only updated on completion,
// so a display driven from BCD never shows a partial value.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [BIN_W-1:0]              BIN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD,
  output logic                          OVF
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BIN_W-1:0]   shift_reg;
  logic [SCR_W-1:0]   scratch_reg;
  logic               sticky_ovf_reg;
  logic [SCR_W-1:0]   bcd_reg;
  logic               ovf_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   scratch_next;
  logic [BIN_W-1:0]   shift_next;
  logic               carry_out;

  // Per-digit add-3 correction applied to the current scratch digits
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One shift step of {scratch, shift}; the bit leaving the top digit means the
  // running value no longer fits in DIGITS decimal digits
  always_comb begin
    scratch_next = {adj[SCR_W-2:0], shift_reg[BIN_W-1]};
    shift_next   = shift_reg << 1;
    carry_out    = adj[SCR_W-1];
  end

  // Control FSM with datapath and registered handshake/result outputs
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      scratch_reg    <= '0;
      sticky_ovf_reg <= 1'b0;
      bcd_reg        <= '0;
      ovf_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            shift_reg      <= BIN;
            scratch_reg    <= '0;
            sticky_ovf_reg <= 1'b0;
            cnt_reg        <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= CONV;
          end
        end
        CONV: begin
          shift_reg      <= shift_next;
          scratch_reg    <= scratch_next;
          sticky_ovf_reg <= sticky_ovf_reg | carry_out;
          cnt_reg        <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            bcd_reg   <= scratch_next;
            ovf_reg   <= sticky_ovf_reg | carry_out;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign BCD  = bcd_reg;
  assign OVF  = ovf_reg;

endmodule : bin2bcd_seq
